// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// One word per line. A single MMIO address bypasses the cache (uncached, read-only).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_re/cpu_we/cpu_addr   CPU load/store request (store wins); addr held while stall=1
//   cpu_wd/cpu_be            store data and byte enables
//   cpu_rd, stall            load data, hold-request indication (both combinational)
//   mem_fetch/mem_addr       line fill request to data memory
//   mem_rd                   data memory read data (combinational)
//   mem_writeback/mem_wb_*   dirty line eviction to data memory
module dcache_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 8,
  parameter logic [31:0] MMIO_ADDR  = 32'h0FC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_re,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wd,
  input  logic [3:0]            cpu_be,
  output logic [DATA_WIDTH-1:0] cpu_rd,
  output logic                  stall,
  output logic                  mem_fetch,
  output logic [31:0]           mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic                  mem_writeback,
  output logic [31:0]           mem_wb_addr,
  output logic [DATA_WIDTH-1:0] mem_wb_data
);

  localparam int unsigned Lines   = 1 << INDEX_BITS;
  localparam int unsigned TagBits = 32 - INDEX_BITS - 2;

  typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

  state_e state_q, state_d;

  logic [Lines-1:0]      valid_q, valid_d;
  logic [Lines-1:0]      dirty_q, dirty_d;
  logic [TagBits-1:0]    tag_q  [Lines];
  logic [DATA_WIDTH-1:0] data_q [Lines];

  logic [INDEX_BITS-1:0] idx;
  logic [TagBits-1:0]    tag;
  logic                  req, mmio, hit;
  logic                  line_fill, store_hit;
  logic [DATA_WIDTH-1:0] merged;

  always_comb begin
    idx  = cpu_addr[INDEX_BITS+1:2];
    tag  = cpu_addr[31:INDEX_BITS+2];
    req  = cpu_re | cpu_we;
    mmio = (cpu_addr == MMIO_ADDR);
    hit  = valid_q[idx] && (tag_q[idx] == tag);
  end

  // Byte-lane merge of store data into the resident word.
  always_comb begin
    merged = data_q[idx];
    for (int i = 0; i < 4; i++) begin
      if (cpu_be[i]) merged[8*i +: 8] = cpu_wd[8*i +: 8];
    end
  end

  always_comb begin
    state_d       = state_q;
    stall         = 1'b0;
    mem_fetch     = 1'b0;
    mem_writeback = 1'b0;
    mem_addr      = cpu_addr;
    mem_wb_addr   = '0;
    mem_wb_data   = '0;
    cpu_rd        = '0;
    line_fill     = 1'b0;
    store_hit     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req && mmio) begin
          // Uncached read; stores to the MMIO address are dropped.
          if (!cpu_we) cpu_rd = mem_rd;
        end else if (req && hit) begin
          if (cpu_we) store_hit = 1'b1;
          else        cpu_rd    = data_q[idx];
        end else if (req) begin
          stall   = 1'b1;
          state_d = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StAllocate;
        end
      end
      StWriteback: begin
        stall         = 1'b1;
        mem_writeback = 1'b1;
        mem_wb_addr   = {tag_q[idx], idx, 2'b00};
        mem_wb_data   = data_q[idx];
        state_d       = StAllocate;
      end
      StAllocate: begin
        stall     = 1'b1;
        mem_fetch = 1'b1;
        mem_addr  = {cpu_addr[31:2], 2'b00};
        line_fill = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs must fall to their reset values as soon as rst rises.
    if (rst) begin
      stall         = 1'b0;
      mem_fetch     = 1'b0;
      mem_writeback = 1'b0;
      mem_addr      = cpu_addr;
      mem_wb_addr   = '0;
      mem_wb_data   = '0;
      cpu_rd        = '0;
      line_fill     = 1'b0;
      store_hit     = 1'b0;
    end
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (line_fill) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end else if (store_hit) begin
      dirty_d[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (line_fill) begin
      data_q[idx] <= mem_rd;
      tag_q[idx]  <= tag;
    end else if (store_hit) begin
      data_q[idx] <= merged;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wd;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rd;
  logic        stall, mem_fetch, mem_writeback;
  logic [31:0] mem_addr, mem_rd, mem_wb_addr, mem_wb_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_re       (cpu_re),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wd       (cpu_wd),
    .cpu_be       (cpu_be),
    .cpu_rd       (cpu_rd),
    .stall        (stall),
    .mem_fetch    (mem_fetch),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_writeback(mem_writeback),
    .mem_wb_addr  (mem_wb_addr),
    .mem_wb_data  (mem_wb_data)
  );

  // Combinational memory model; MMIO trigger reads as 1.
  always_comb begin
    if (mem_addr == 32'h0FC)        mem_rd = 32'h1;
    else if (mem_addr == 32'h10000) mem_rd = 32'hDEADBEEF;
    else if (mem_addr == 32'h10400) mem_rd = 32'h12345678;
    else                            mem_rd = 32'hA5A50000 ^ mem_addr;
  end

  typedef struct {
    logic        re, we;
    logic [31:0] addr, wd;
    logic [3:0]  be;
    logic        stall, fetch, wb;
    logic [31:0] rd, maddr, wb_addr, wb_data;
  } vec_t;

  localparam int NVec = 20;
  vec_t vecs [NVec];

  function automatic vec_t mk(logic re, logic we, logic [31:0] addr, logic [31:0] wd,
                              logic [3:0] be, logic st, logic fe, logic wb, logic [31:0] rd,
                              logic [31:0] maddr, logic [31:0] wba, logic [31:0] wbd);
    vec_t v;
    v.re = re; v.we = we; v.addr = addr; v.wd = wd; v.be = be;
    v.stall = st; v.fetch = fe; v.wb = wb; v.rd = rd; v.maddr = maddr;
    v.wb_addr = wba; v.wb_data = wbd;
    return v;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %h, want %h", nm, id, act, exp);
    end
  endtask

  task automatic drive(input logic re, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_wd = wd; cpu_be = be;
  endtask

  int stall_cycles;
  logic saw_wb, saw_fetch, done;

  initial begin
    // re we addr wd be | stall fetch wb rd mem_addr wb_addr wb_data
    vecs[0]  = mk(1, 0, 32'h10000, 0, 0,           1, 0, 0, 0, 32'h10000, 0, 0);
    vecs[1]  = mk(1, 0, 32'h10000, 0, 0,           1, 1, 0, 0, 32'h10000, 0, 0);
    vecs[2]  = mk(1, 0, 32'h10000, 0, 0,           0, 0, 0, 32'hDEADBEEF, 32'h10000, 0, 0);
    vecs[3]  = mk(1, 0, 32'h10000, 0, 0,           0, 0, 0, 32'hDEADBEEF, 32'h10000, 0, 0);
    vecs[4]  = mk(0, 1, 32'h10000, 32'hAB, 4'b0001, 0, 0, 0, 0, 32'h10000, 0, 0);
    vecs[5]  = mk(1, 0, 32'h10000, 0, 0,           0, 0, 0, 32'hDEADBEAB, 32'h10000, 0, 0);
    vecs[6]  = mk(1, 0, 32'h10400, 0, 0,           1, 0, 0, 0, 32'h10400, 0, 0);
    vecs[7]  = mk(1, 0, 32'h10400, 0, 0,           1, 0, 1, 0, 32'h10400, 32'h10000,
                  32'hDEADBEAB);
    vecs[8]  = mk(1, 0, 32'h10400, 0, 0,           1, 1, 0, 0, 32'h10400, 0, 0);
    vecs[9]  = mk(1, 0, 32'h10400, 0, 0,           0, 0, 0, 32'h12345678, 32'h10400, 0, 0);
    vecs[10] = mk(1, 0, 32'h0FC, 0, 0,             0, 0, 0, 32'h1, 32'h0FC, 0, 0);
    vecs[11] = mk(1, 0, 32'h10400, 0, 0,           0, 0, 0, 32'h12345678, 32'h10400, 0, 0);
    vecs[12] = mk(0, 0, 32'h10400, 0, 0,           0, 0, 0, 0, 32'h10400, 0, 0);
    // Clean store miss: allocate, then merge bytes 1..2 on the hit cycle.
    vecs[13] = mk(0, 1, 32'h20000, 32'h11223344, 4'b0110, 1, 0, 0, 0, 32'h20000, 0, 0);
    vecs[14] = mk(0, 1, 32'h20000, 32'h11223344, 4'b0110, 1, 1, 0, 0, 32'h20000, 0, 0);
    vecs[15] = mk(0, 1, 32'h20000, 32'h11223344, 4'b0110, 0, 0, 0, 0, 32'h20000, 0, 0);
    vecs[16] = mk(1, 0, 32'h20000, 0, 0,           0, 0, 0, 32'hA5223300, 32'h20000, 0, 0);
    vecs[17] = mk(0, 1, 32'h0FC, 32'hFFFFFFFF, 4'b1111, 0, 0, 0, 0, 32'h0FC, 0, 0);
    // Both re and we: store wins, cpu_rd stays 0.
    vecs[18] = mk(1, 1, 32'h20000, 32'hEE, 4'b0001, 0, 0, 0, 0, 32'h20000, 0, 0);
    vecs[19] = mk(1, 0, 32'h20000, 0, 0,           0, 0, 0, 32'hA52233EE, 32'h20000, 0, 0);

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h10000, 32'h0, 4'h0);
    #2;
    chk("rst_stall", 0, {31'b0, stall}, 0);
    chk("rst_fetch", 0, {31'b0, mem_fetch}, 0);
    chk("rst_wb", 0, {31'b0, mem_writeback}, 0);
    chk("rst_rd", 0, cpu_rd, 0);
    chk("rst_wb_addr", 0, mem_wb_addr, 0);
    chk("rst_wb_data", 0, mem_wb_data, 0);
    chk("rst_mem_addr", 0, mem_addr, 32'h10000);

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVec; i++) begin
      drive(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].be);
      #2;
      chk("stall", i, {31'b0, stall}, {31'b0, vecs[i].stall});
      chk("fetch", i, {31'b0, mem_fetch}, {31'b0, vecs[i].fetch});
      chk("writeback", i, {31'b0, mem_writeback}, {31'b0, vecs[i].wb});
      chk("cpu_rd", i, cpu_rd, vecs[i].rd);
      chk("mem_addr", i, mem_addr, vecs[i].maddr);
      chk("wb_addr", i, mem_wb_addr, vecs[i].wb_addr);
      chk("wb_data", i, mem_wb_data, vecs[i].wb_data);
      @(negedge clk);
    end

    // Line 0 now holds dirty 0x20000; a load of 0x10400 enters WRITEBACK.
    drive(1'b1, 1'b0, 32'h10400, 32'h0, 4'h0);
    #2;
    chk("pre_wb_stall", 100, {31'b0, stall}, 1);
    @(posedge clk);
    #2;
    chk("in_wb", 101, {31'b0, mem_writeback}, 1);
    rst = 1'b1;
    #1;
    chk("rst_wb_drop", 102, {31'b0, mem_writeback}, 0);
    chk("rst_wb_stall", 102, {31'b0, stall}, 0);
    chk("rst_wb_fetch", 102, {31'b0, mem_fetch}, 0);
    chk("rst_wb_addr0", 102, mem_wb_addr, 0);
    @(negedge clk);
    rst = 1'b0;

    // Valid bits were cleared: expect a clean miss (2 stall cycles, no writeback).
    stall_cycles = 0;
    saw_wb = 1'b0;
    saw_fetch = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      #2;
      if (mem_writeback) saw_wb = 1'b1;
      if (mem_fetch) saw_fetch = 1'b1;
      if (stall) begin
        stall_cycles++;
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    chk("post_rst_done", 103, {31'b0, done}, 1);
    chk("post_rst_stalls", 103, stall_cycles, 2);
    chk("post_rst_no_wb", 103, {31'b0, saw_wb}, 0);
    chk("post_rst_fetch", 103, {31'b0, saw_fetch}, 1);
    chk("post_rst_rd", 103, cpu_rd, 32'h12345678);

    drive(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
